// File: rtl/io_1ton_ck_pkg.sv
// Shared definitions for the one-to-N routing traffic harness: default
// channel widths, source FSM state encodings and the address-to-sink map.
package io_1ton_ck_pkg;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;

    typedef enum logic [1:0] {
        NS_IO_IDLE     = 2'd0,
        NS_IO_REQ      = 2'd1,
        NS_IO_WAIT_LOW = 2'd2,
        NS_IO_DONE     = 2'd3
    } io_src_state_e;

    // Target sink of an address: low bits of (addr - min_addr); num_snk is a power of two.
    function automatic logic [31:0] tgt_snk(input logic [31:0] addr,
                                            input logic [31:0] min_addr,
                                            input logic [31:0] num_snk);
        return (addr - min_addr) & (num_snk - 32'd1);
    endfunction

endpackage

// File: rtl/io_1ton_ck_if.sv
// Channel bundle between the harness (master) and the network under test
// (slave): one source channel out, NUM_SNK packed sink channels back in.
interface io_1ton_ck_if #(
    parameter int NUM_SNK = 2,
    parameter int ASZ     = io_1ton_ck_pkg::NS_ADDRESS_SIZE,
    parameter int DSZ     = io_1ton_ck_pkg::NS_DATA_SIZE
);
    logic [ASZ-1:0]         o0_src;
    logic [ASZ-1:0]         o0_dst;
    logic [DSZ-1:0]         o0_dat;
    logic                   o0_req;
    logic                   o0_ack;
    logic [NUM_SNK-1:0]     i_req;
    logic [NUM_SNK*ASZ-1:0] i_src;
    logic [NUM_SNK*ASZ-1:0] i_dst;
    logic [NUM_SNK*DSZ-1:0] i_dat;
    logic [NUM_SNK-1:0]     i_ack;

    modport master (
        output o0_src, o0_dst, o0_dat, o0_req,
        input  o0_ack,
        input  i_req, i_src, i_dst, i_dat,
        output i_ack
    );

    modport slave (
        input  o0_src, o0_dst, o0_dat, o0_req,
        output o0_ack,
        output i_req, i_src, i_dst, i_dat,
        input  i_ack
    );
endinterface

// File: rtl/io_snk_ck.sv
// Single sink checker: 4-phase acknowledge, routing/tag/sequence checks,
// saturating receive counter and first-error capture.
module io_snk_ck
    import io_1ton_ck_pkg::*;
#(
    parameter int NUM_SNK  = 2,
    parameter int MIN_ADDR = 0,
    parameter int ASZ      = NS_ADDRESS_SIZE,
    parameter int DSZ      = NS_DATA_SIZE,
    parameter int SEQ_SZ   = 4,
    parameter int SNK_IDX  = 0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           req,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic           ack,
    output logic           err,
    output logic [15:0]    rcv_cnt,
    output logic [DSZ-1:0] fst_err_inp,
    output logic [DSZ-1:0] fst_err_dat
);
    localparam int SSZ = $clog2(NUM_SNK);

    logic              ack_r;
    logic              err_r;
    logic              valid_r;
    logic [SEQ_SZ-1:0] last_seq_r;
    logic [15:0]       cnt_r;
    logic [DSZ-1:0]    fst_inp_r;
    logic [DSZ-1:0]    fst_dat_r;

    logic              accept_s;
    logic              release_s;
    logic [SEQ_SZ-1:0] seq_s;
    logic [SSZ-1:0]    tag_s;
    logic [SSZ-1:0]    route_s;
    logic [SEQ_SZ-1:0] exp_seq_s;
    logic              err_now_s;
    logic [DSZ-1:0]    exp_dat_s;

    // Decode the offered message and evaluate all three checks against it.
    always_comb begin
        accept_s  = req & ~ack_r;
        release_s = ~req & ack_r;
        seq_s     = dat[SEQ_SZ-1:0];
        tag_s     = dat[SEQ_SZ +: SSZ];
        route_s   = SSZ'(tgt_snk(32'(dst), 32'(MIN_ADDR), 32'(NUM_SNK)));
        if (valid_r) begin
            exp_seq_s = last_seq_r + SEQ_SZ'(1);
        end else begin
            exp_seq_s = '0;
        end
        err_now_s = (route_s != SSZ'(SNK_IDX)) ||
                    (tag_s != SSZ'(SNK_IDX)) ||
                    (valid_r && (seq_s != exp_seq_s));
        exp_dat_s = '0;
        exp_dat_s[SEQ_SZ-1:0]   = exp_seq_s;
        exp_dat_s[SEQ_SZ +: SSZ] = SSZ'(SNK_IDX);
    end

    // Accept/release handshake and update of counters, sequence and error capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            valid_r    <= 1'b0;
            last_seq_r <= '0;
            cnt_r      <= 16'd0;
            fst_inp_r  <= '0;
            fst_dat_r  <= '0;
        end else if (accept_s) begin
            ack_r      <= 1'b1;
            valid_r    <= 1'b1;
            last_seq_r <= seq_s;
            if (cnt_r != 16'hFFFF) begin
                cnt_r <= cnt_r + 16'd1;
            end
            if (err_now_s) begin
                err_r <= 1'b1;
                if (!err_r) begin
                    fst_inp_r <= dat;
                    fst_dat_r <= exp_dat_s;
                end
            end
        end else if (release_s) begin
            ack_r <= 1'b0;
        end
    end

    assign ack         = ack_r;
    assign err         = err_r;
    assign rcv_cnt     = cnt_r;
    assign fst_err_inp = fst_inp_r;
    assign fst_err_dat = fst_dat_r;

endmodule

// File: rtl/io_1ton_ck.sv
// Self-checking one-source / N-sink traffic harness wrapped around a routing
// fabric: the source walks destination addresses stamping tag and per-sink
// sequence numbers, each sink checker validates what arrives.
module io_1ton_ck
    import io_1ton_ck_pkg::*;
#(
    parameter int NUM_SNK  = 2,
    parameter int MIN_ADDR = 0,
    parameter int MAX_ADDR = 3,
    parameter int ASZ      = NS_ADDRESS_SIZE,
    parameter int DSZ      = NS_DATA_SIZE,
    parameter int SEQ_SZ   = 4,
    parameter int NUM_MSGS = 0,
    parameter int TMO      = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    io_1ton_ck_if.master           bus,
    output logic                   o_src_err,
    output logic [NUM_SNK-1:0]     o_snk_err,
    output logic [NUM_SNK*16-1:0]  o_rcv_cnt,
    output logic [NUM_SNK*DSZ-1:0] o_fst_err_inp,
    output logic [NUM_SNK*DSZ-1:0] o_fst_err_dat,
    output logic                   o_done
);
    localparam int SSZ     = $clog2(NUM_SNK);
    localparam int WDW     = $clog2(TMO + 1);
    localparam bit LIMITED = (NUM_MSGS != 0);

    io_src_state_e     state_r, state_nx_s;
    logic [ASZ-1:0]    dst_r, dst_nx_s;
    logic [DSZ-1:0]    dat_r, dat_nx_s;
    logic              req_r, req_nx_s;
    logic [SEQ_SZ-1:0] seq_r    [NUM_SNK];
    logic [SEQ_SZ-1:0] seq_nx_s [NUM_SNK];
    logic [31:0]       sent_r, sent_nx_s;
    logic [WDW-1:0]    wdog_r, wdog_nx_s;
    logic              src_err_r, src_err_nx_s;
    logic              done_r;

    logic [SSZ-1:0]    tgt_s;
    logic              limit_s;
    logic [DSZ-1:0]    msg_dat_s;
    logic [WDW-1:0]    wdog_inc_s;
    logic [ASZ-1:0]    dst_adv_s;
    logic [31:0]       sum_s;

    logic [NUM_SNK-1:0] ack_s;
    logic [NUM_SNK-1:0] snk_err_s;
    logic [15:0]        cnt_s [NUM_SNK];
    logic               unused_src_s;

    // Message being offered, next address and saturating watchdog increment.
    always_comb begin
        tgt_s     = SSZ'(tgt_snk(32'(dst_r), 32'(MIN_ADDR), 32'(NUM_SNK)));
        limit_s   = LIMITED && (sent_r >= 32'(NUM_MSGS));
        msg_dat_s = '0;
        msg_dat_s[SEQ_SZ-1:0]    = seq_r[tgt_s];
        msg_dat_s[SEQ_SZ +: SSZ] = tgt_s;
        if (wdog_r == WDW'(TMO)) begin
            wdog_inc_s = wdog_r;
        end else begin
            wdog_inc_s = wdog_r + WDW'(1);
        end
        if (dst_r == ASZ'(MAX_ADDR)) begin
            dst_adv_s = ASZ'(MIN_ADDR);
        end else begin
            dst_adv_s = dst_r + ASZ'(1);
        end
    end

    // Source FSM next state and datapath next values.
    always_comb begin
        state_nx_s   = state_r;
        dst_nx_s     = dst_r;
        dat_nx_s     = dat_r;
        req_nx_s     = req_r;
        seq_nx_s     = seq_r;
        sent_nx_s    = sent_r;
        wdog_nx_s    = wdog_r;
        src_err_nx_s = src_err_r;
        case (state_r)
            NS_IO_IDLE: begin
                if (!bus.o0_ack && !limit_s) begin
                    dat_nx_s   = msg_dat_s;
                    req_nx_s   = 1'b1;
                    wdog_nx_s  = '0;
                    state_nx_s = NS_IO_REQ;
                end else begin
                    state_nx_s = NS_IO_IDLE;
                end
            end
            NS_IO_REQ: begin
                if (bus.o0_ack) begin
                    seq_nx_s[tgt_s] = seq_r[tgt_s] + SEQ_SZ'(1);
                    dst_nx_s        = dst_adv_s;
                    sent_nx_s       = sent_r + 32'd1;
                    req_nx_s        = 1'b0;
                    wdog_nx_s       = '0;
                    state_nx_s      = NS_IO_WAIT_LOW;
                end else begin
                    wdog_nx_s = wdog_inc_s;
                    if (wdog_inc_s == WDW'(TMO)) begin
                        src_err_nx_s = 1'b1;
                    end else begin
                        src_err_nx_s = src_err_r;
                    end
                end
            end
            NS_IO_WAIT_LOW: begin
                if (!bus.o0_ack) begin
                    wdog_nx_s = '0;
                    if (LIMITED && (sent_r == 32'(NUM_MSGS))) begin
                        state_nx_s = NS_IO_DONE;
                    end else begin
                        state_nx_s = NS_IO_IDLE;
                    end
                end else begin
                    wdog_nx_s = wdog_inc_s;
                    if (wdog_inc_s == WDW'(TMO)) begin
                        src_err_nx_s = 1'b1;
                    end else begin
                        src_err_nx_s = src_err_r;
                    end
                end
            end
            NS_IO_DONE: begin
                state_nx_s = NS_IO_DONE;
            end
            default: begin
                state_nx_s = NS_IO_IDLE;
                req_nx_s   = 1'b0;
            end
        endcase
    end

    // Source FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= NS_IO_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Source datapath registers: channel outputs, sequence table, counters, watchdog.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dst_r     <= ASZ'(MIN_ADDR);
            dat_r     <= '0;
            req_r     <= 1'b0;
            sent_r    <= 32'd0;
            wdog_r    <= '0;
            src_err_r <= 1'b0;
            for (int k = 0; k < NUM_SNK; k++) begin
                seq_r[k] <= '0;
            end
        end else begin
            dst_r     <= dst_nx_s;
            dat_r     <= dat_nx_s;
            req_r     <= req_nx_s;
            sent_r    <= sent_nx_s;
            wdog_r    <= wdog_nx_s;
            src_err_r <= src_err_nx_s;
            seq_r     <= seq_nx_s;
        end
    end

    // Total messages accepted across all sinks.
    always_comb begin
        sum_s = 32'd0;
        for (int k = 0; k < NUM_SNK; k++) begin
            sum_s = sum_s + {16'd0, cnt_s[k]};
        end
    end

    // Completion flag: source finished and every message arrived somewhere.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= LIMITED && (state_r == NS_IO_DONE) && (sum_s == 32'(NUM_MSGS));
        end
    end

    for (genvar k = 0; k < NUM_SNK; k++) begin : g_snk
        io_snk_ck #(
            .NUM_SNK  (NUM_SNK),
            .MIN_ADDR (MIN_ADDR),
            .ASZ      (ASZ),
            .DSZ      (DSZ),
            .SEQ_SZ   (SEQ_SZ),
            .SNK_IDX  (k)
        ) u_snk (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .req         (bus.i_req[k]),
            .dst         (bus.i_dst[k*ASZ +: ASZ]),
            .dat         (bus.i_dat[k*DSZ +: DSZ]),
            .ack         (ack_s[k]),
            .err         (snk_err_s[k]),
            .rcv_cnt     (cnt_s[k]),
            .fst_err_inp (o_fst_err_inp[k*DSZ +: DSZ]),
            .fst_err_dat (o_fst_err_dat[k*DSZ +: DSZ])
        );
        assign o_rcv_cnt[k*16 +: 16] = cnt_s[k];
    end

    // The sink source address is carried by the fabric but not checked.
    assign unused_src_s = ^bus.i_src;

    assign bus.o0_src = '0;
    assign bus.o0_dst = dst_r;
    assign bus.o0_dat = dat_r;
    assign bus.o0_req = req_r;
    assign bus.i_ack  = ack_s;
    assign o_src_err  = src_err_r;
    assign o_snk_err  = snk_err_s;
    assign o_done     = done_r;

endmodule
